mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Two-requester round-robin arbiter in front of a single-port synchronous
// memory. Exactly one access is in flight at a time and every access, read
// or write, completes with a one-cycle ack pulse three cycles after the
// request is first sampled (IDLE -> ACCESS -> READ -> IDLE).
module mem_arbiter #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,

  input  logic             i_req0,
  input  logic             i_we0,
  input  logic [DEPTH-1:0] i_addr0,
  input  logic [WIDTH-1:0] i_dat0,
  output logic             o_ack0,
  output logic [WIDTH-1:0] o_dat0,

  input  logic             i_req1,
  input  logic             i_we1,
  input  logic [DEPTH-1:0] i_addr1,
  input  logic [WIDTH-1:0] i_dat1,
  output logic             o_ack1,
  output logic [WIDTH-1:0] o_dat1,

  output logic [DEPTH-1:0] o_mem_addr,
  output logic [WIDTH-1:0] o_mem_dat,
  output logic             o_mem_cs,
  output logic             o_mem_we,
  input  logic [WIDTH-1:0] i_mem_dat,

  output logic             o_busy
);

  // FSM encoding
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_READ   = 2'd2;

  // Round-robin pick: on contention the requester that did not win last
  // time gets the slot; a lone eligible requester always wins.
  // Returns the index (0/1) of the winner; only meaningful when at least
  // one requester is eligible.
  function automatic logic pick_winner(input logic elig0,
                                       input logic elig1,
                                       input logic last_gnt);
    logic win;
    if (elig0 && elig1) begin
      win = ~last_gnt;
    end else if (elig1) begin
      win = 1'b1;
    end else begin
      win = 1'b0;
    end
    return win;
  endfunction

  // State and registered outputs
  logic [1:0]       state_q,    state_d;
  logic             grant_q,    grant_d;     // owner of the access in flight
  logic             last_q,     last_d;      // last requester granted
  logic [DEPTH-1:0] mem_addr_q, mem_addr_d;
  logic [WIDTH-1:0] mem_dat_q,  mem_dat_d;
  logic             mem_cs_q,   mem_cs_d;
  logic             mem_we_q,   mem_we_d;
  logic             ack0_q,     ack0_d;
  logic             ack1_q,     ack1_d;
  logic [WIDTH-1:0] dat0_q,     dat0_d;
  logic [WIDTH-1:0] dat1_q,     dat1_d;
  logic             busy_q,     busy_d;

  // Combinational arbitration signals
  logic elig0_s;
  logic elig1_s;
  logic any_elig_s;
  logic win_s;
  logic launch_s;

  // Eligibility: a request is ignored during its own ack cycle so a
  // requester that has not yet dropped req is not granted a second time.
  always_comb begin
    elig0_s    = i_req0 & ~ack0_q;
    elig1_s    = i_req1 & ~ack1_q;
    any_elig_s = elig0_s | elig1_s;
    win_s      = pick_winner(elig0_s, elig1_s, last_q);
    launch_s   = (state_q == ST_IDLE) & any_elig_s;
  end

  // FSM next state plus grant bookkeeping; the last-grant register only
  // moves when a new access is launched.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (launch_s) begin
          state_d = ST_ACCESS;
          grant_d = win_s;
          last_d  = win_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        state_d = ST_READ;
      end
      ST_READ: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Memory port: address/data/we of the winner are latched at launch and
  // cs is high only for the single ACCESS cycle; addr/data hold afterwards.
  always_comb begin
    mem_addr_d = mem_addr_q;
    mem_dat_d  = mem_dat_q;
    mem_cs_d   = 1'b0;
    mem_we_d   = 1'b0;
    if (launch_s) begin
      mem_cs_d = 1'b1;
      if (win_s) begin
        mem_addr_d = i_addr1;
        mem_dat_d  = i_dat1;
        mem_we_d   = i_we1;
      end else begin
        mem_addr_d = i_addr0;
        mem_dat_d  = i_dat0;
        mem_we_d   = i_we0;
      end
    end else begin
      mem_cs_d = 1'b0;
      mem_we_d = 1'b0;
    end
  end

  // Completion: in READ the memory's registered output is captured into the
  // owner's data register and its ack pulses; the other side holds its data.
  always_comb begin
    ack0_d = 1'b0;
    ack1_d = 1'b0;
    dat0_d = dat0_q;
    dat1_d = dat1_q;
    if (state_q == ST_READ) begin
      if (grant_q) begin
        ack1_d = 1'b1;
        dat1_d = i_mem_dat;
      end else begin
        ack0_d = 1'b1;
        dat0_d = i_mem_dat;
      end
    end else begin
      ack0_d = 1'b0;
      ack1_d = 1'b0;
    end
  end

  // Busy flag registered alongside the state so it tracks "not IDLE".
  always_comb begin
    busy_d = (state_d != ST_IDLE);
  end

  // State registers with synchronous reset; reset aborts any access.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= ST_IDLE;
      grant_q    <= 1'b0;
      last_q     <= 1'b1;
      mem_addr_q <= {DEPTH{1'b0}};
      mem_dat_q  <= {WIDTH{1'b0}};
      mem_cs_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      dat0_q     <= {WIDTH{1'b0}};
      dat1_q     <= {WIDTH{1'b0}};
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      mem_addr_q <= mem_addr_d;
      mem_dat_q  <= mem_dat_d;
      mem_cs_q   <= mem_cs_d;
      mem_we_q   <= mem_we_d;
      ack0_q     <= ack0_d;
      ack1_q     <= ack1_d;
      dat0_q     <= dat0_d;
      dat1_q     <= dat1_d;
      busy_q     <= busy_d;
    end
  end

  assign o_mem_addr = mem_addr_q;
  assign o_mem_dat  = mem_dat_q;
  assign o_mem_cs   = mem_cs_q;
  assign o_mem_we   = mem_we_q;
  assign o_ack0     = ack0_q;
  assign o_ack1     = ack1_q;
  assign o_dat0     = dat0_q;
  assign o_dat1     = dat1_q;
  assign o_busy     = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Directed scenarios followed by random two-requester traffic. Expected
// outputs come from a transaction-level model: each grant books the
// arbiter for three edges, the ack lands two edges after the grant, and
// data comes from a reference memory array.
module tb_mem_arbiter;
  localparam int DEPTH = 16;
  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_v  [2];
  logic             we_v   [2];
  logic [DEPTH-1:0] addr_v [2];
  logic [WIDTH-1:0] wdat_v [2];
  logic             o_ack0, o_ack1;
  logic [WIDTH-1:0] o_dat0, o_dat1;
  logic [DEPTH-1:0] mem_addr;
  logic [WIDTH-1:0] mem_dat;
  logic [WIDTH-1:0] mem_rd;
  logic             mem_cs, mem_we, busy;

  int n_err = 0;
  int n_chk = 0;
  int cyc   = 0;

  // clock generation
  always #5 clk = ~clk;

  mem_arbiter #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_req0(req_v[0]), .i_we0(we_v[0]), .i_addr0(addr_v[0]), .i_dat0(wdat_v[0]),
    .o_ack0(o_ack0), .o_dat0(o_dat0),
    .i_req1(req_v[1]), .i_we1(we_v[1]), .i_addr1(addr_v[1]), .i_dat1(wdat_v[1]),
    .o_ack1(o_ack1), .o_dat1(o_dat1),
    .o_mem_addr(mem_addr), .o_mem_dat(mem_dat), .o_mem_cs(mem_cs),
    .o_mem_we(mem_we), .i_mem_dat(mem_rd), .o_busy(busy)
  );

  // power-up memory content (0x1234 -> 0xA5)
  function automatic logic [7:0] init_val(input logic [15:0] a);
    return a[15:8] ^ a[7:0] ^ 8'h83;
  endfunction

  // bench memory: registered read, write-first
  logic [7:0] bmem [0:65535];
  bit         bwr  [0:65535];
  always @(posedge clk) begin
    if (mem_cs === 1'b1) begin
      if (mem_we) begin
        bmem[mem_addr] <= mem_dat;
        bwr[mem_addr]  <= 1'b1;
        mem_rd         <= mem_dat;
      end else begin
        mem_rd <= bwr[mem_addr] ? bmem[mem_addr] : init_val(mem_addr);
      end
    end
  end

  // reference model state
  logic [7:0] rmem [0:65535];
  bit         rwr  [0:65535];
  int         m_free, m_done, m_gedge;
  bit         m_inflight;
  logic       m_last, m_gid;
  logic [7:0] m_rdat;
  logic       x_ack [2];
  logic [7:0] x_dat [2];
  logic       x_cs, x_we, x_busy;
  logic [15:0] x_addr;
  logic [7:0]  x_mdat;

  // directed / random bookkeeping
  bit dropn [2];
  int wcnt  [2];
  int ids [$];
  int tms [$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // model update for the edge just taken (uses pre-edge inputs)
  task automatic model_edge();
    int   e;
    logic el0, el1, g;
    e = cyc;
    if (rst) begin
      m_last = 1'b1; m_inflight = 1'b0; m_free = e + 1; m_done = -100; m_gedge = -100;
      x_ack[0] = 1'b0; x_ack[1] = 1'b0; x_dat[0] = 8'h00; x_dat[1] = 8'h00;
      x_cs = 1'b0; x_we = 1'b0; x_busy = 1'b0; x_addr = 16'h0000; x_mdat = 8'h00;
    end else begin
      el0 = req_v[0] && !x_ack[0];
      el1 = req_v[1] && !x_ack[1];
      x_ack[0] = 1'b0; x_ack[1] = 1'b0;
      if (m_inflight && e == m_done) begin
        x_ack[m_gid] = 1'b1;
        x_dat[m_gid] = m_rdat;
        m_inflight = 1'b0;
      end
      x_cs = 1'b0; x_we = 1'b0;
      if (!m_inflight && e >= m_free && (el0 || el1)) begin
        g = (el0 && el1) ? ~m_last : el1;
        m_last = g; m_gid = g; m_inflight = 1'b1;
        m_done = e + 2; m_free = e + 3; m_gedge = e;
        x_cs = 1'b1; x_we = we_v[g]; x_addr = addr_v[g]; x_mdat = wdat_v[g];
        if (we_v[g]) begin
          rmem[addr_v[g]] = wdat_v[g]; rwr[addr_v[g]] = 1'b1; m_rdat = wdat_v[g];
        end else begin
          m_rdat = rwr[addr_v[g]] ? rmem[addr_v[g]] : init_val(addr_v[g]);
        end
      end
      x_busy = m_inflight && ((e - m_gedge) < 2);
    end
  endtask

  task automatic compare_all();
    check_eq("ack0", o_ack0, x_ack[0]);
    check_eq("ack1", o_ack1, x_ack[1]);
    check_eq("dat0", o_dat0, x_dat[0]);
    check_eq("dat1", o_dat1, x_dat[1]);
    check_eq("mem_cs", mem_cs, x_cs);
    check_eq("mem_we", mem_we, x_we);
    check_eq("busy", busy, x_busy);
    check_eq("mem_addr", mem_addr, x_addr);
    check_eq("mem_dat", mem_dat, x_mdat);
    check_eq("ack_excl", o_ack0 & o_ack1, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
    cyc++;
  endtask

  // one directed transaction, req held through its ack cycle
  task automatic run_txn(input int k, input logic we, input logic [15:0] a,
                         input logic [7:0] d, output int lat, output logic [7:0] rd);
    int cs_cnt, we_cnt;
    cs_cnt = 0; we_cnt = 0; lat = -1; rd = 8'h00;
    we_v[k] = we; addr_v[k] = a; wdat_v[k] = d; req_v[k] = 1'b1;
    for (int i = 1; i <= 10 && lat < 0; i++) begin
      step();
      if (mem_cs) cs_cnt++;
      if (mem_we) we_cnt++;
      if ((k == 0) ? o_ack0 : o_ack1) begin
        lat = i;
        rd = (k == 0) ? o_dat0 : o_dat1;
      end
    end
    check_eq("txn_lat", lat, 3);
    check_eq("txn_cs_cycles", cs_cnt, 1);
    check_eq("txn_we_cycles", we_cnt, {31'd0, we});
    step();
    check_eq("no_regrant", mem_cs, 1'b0);
    req_v[k] = 1'b0;
  endtask

  // random requester: hold until ack, keep req through the ack cycle
  task automatic drive_req(input int k);
    logic ack_seen;
    ack_seen = (k == 0) ? o_ack0 : o_ack1;
    if (dropn[k]) begin
      req_v[k] = 1'b0;
      dropn[k] = 1'b0;
    end else if (req_v[k]) begin
      if (rst) wcnt[k] = 0;
      else     wcnt[k]++;
      if (ack_seen) begin
        check_eq("ack_within_7", 32'(wcnt[k] <= 7), 32'd1);
        dropn[k] = 1'b1;
      end else if (wcnt[k] > 7) begin
        check_eq("ack_within_7", 32'(wcnt[k] <= 7), 32'd1);
        req_v[k] = 1'b0;
      end
    end
    if (!req_v[k] && !dropn[k] && $urandom_range(0, 2) != 0) begin
      we_v[k]   = 1'($urandom_range(0, 1));
      addr_v[k] = 16'($urandom_range(0, 15));
      wdat_v[k] = 8'($urandom_range(0, 255));
      req_v[k]  = 1'b1;
      wcnt[k]   = 0;
    end
  endtask

  initial begin
    int         lat;
    logic [7:0] rd;
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      req_v[k] = 1'b0; we_v[k] = 1'b0; addr_v[k] = 16'h0000; wdat_v[k] = 8'h00;
      dropn[k] = 1'b0; wcnt[k] = 0;
    end

    // reset values
    step(); step();
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_cs", mem_cs, 1'b0);
    check_eq("rst_addr", mem_addr, 16'h0000);
    rst = 1'b0;
    step();

    // single read of preloaded 0x1234
    run_txn(0, 1'b0, 16'h1234, 8'h00, lat, rd);
    check_eq("rd_1234", rd, 8'hA5);

    // write then read back on requester 1
    run_txn(1, 1'b1, 16'h0010, 8'h5A, lat, rd);
    run_txn(1, 1'b0, 16'h0010, 8'h00, lat, rd);
    check_eq("wr_rd_0010", rd, 8'h5A);

    // contention right after reset, both held continuously
    rst = 1'b1; step(); rst = 1'b0;
    we_v[0] = 1'b0; addr_v[0] = 16'h0001;
    we_v[1] = 1'b0; addr_v[1] = 16'h0002;
    req_v[0] = 1'b1; req_v[1] = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      step();
      if (o_ack0) begin ids.push_back(0); tms.push_back(i); end
      if (o_ack1) begin ids.push_back(1); tms.push_back(i); end
    end
    check_eq("rr_nacks", ids.size(), 4);
    if (ids.size() >= 4) begin
      check_eq("rr_first_lat", tms[0], 3);
      for (int k = 0; k < 4; k++) check_eq("rr_order", ids[k], k % 2);
      for (int k = 1; k < 4; k++) check_eq("rr_gap", tms[k] - tms[k-1], 3);
    end
    req_v[0] = 1'b0; req_v[1] = 1'b0;
    for (int i = 0; i < 4; i++) step();

    // reset while a read sits in READ
    rst = 1'b1; step(); rst = 1'b0;
    we_v[0] = 1'b0; addr_v[0] = 16'h1234; req_v[0] = 1'b1;
    step(); step();
    rst = 1'b1; step(); rst = 1'b0;
    check_eq("abort_ack0", o_ack0, 1'b0);
    check_eq("abort_busy", busy, 1'b0);
    check_eq("abort_dat0", o_dat0, 8'h00);
    check_eq("abort_cs", mem_cs, 1'b0);
    lat = -1;
    for (int i = 1; i <= 8 && lat < 0; i++) begin
      step();
      if (o_ack0) begin lat = i; rd = o_dat0; end
    end
    check_eq("post_rst_lat", lat, 3);
    check_eq("post_rst_dat", rd, 8'hA5);
    step();
    req_v[0] = 1'b0;
    step();

    // random traffic with occasional resets
    for (int c = 0; c < 1500; c++) begin
      rst = ($urandom_range(0, 79) == 0);
      step();
      drive_req(0);
      drive_req(1);
    end
    rst = 1'b0;
    req_v[0] = 1'b0; req_v[1] = 1'b0;
    for (int i = 0; i < 4; i++) step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
